// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and feeds the
// decoder through a registered IF/ID boundary with a 1-entry skid. Optional: IF_MISALIGN_EXP_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_insn,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_exp_misalign
);

  // imem handshake: a request is accepted in a cycle where imem_req && imem_gnt; exactly one
  // imem_rvalid follows, at least one cycle later. Only one request is ever outstanding.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic        skid_valid;
  logic [31:0] skid_insn;
  logic [31:0] skid_pc;
  logic        trap;
  logic        redir;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic        gnt_ok;
  logic        deliver;

  assign tgt_raw = flush ? flush_pc : br_addr;

`ifdef IF_MISALIGN_EXP_EN
  // While trapped the exception sits in IF/ID as a valid slot, so only flush may leave it.
  assign tgt             = tgt_raw;
  assign tgt_mis         = |tgt_raw[1:0];
  assign redir           = flush || (br_taken && if_valid && !stall && !trap);
  assign if_exp_misalign = trap;
`else
  assign tgt             = tgt_raw & ~32'h3;
  assign tgt_mis         = 1'b0;
  assign redir           = flush || (br_taken && if_valid && !stall);
  assign if_exp_misalign = 1'b0;
`endif

  assign imem_req  = (state == S_REQ) && !skid_valid && !trap;
  assign imem_addr = pc;
  assign gnt_ok    = imem_req && imem_gnt;
  assign deliver   = (state == S_WAIT) && imem_rvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (gnt_ok) state_nxt = redir ? S_DROP : S_WAIT;
      S_WAIT:  begin
        if (imem_rvalid)  state_nxt = S_REQ;
        else if (redir)   state_nxt = S_DROP;
      end
      S_DROP:  if (imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      skid_valid <= 1'b0;
      skid_insn  <= 32'h0;
      skid_pc    <= 32'h0;
      trap       <= 1'b0;
      if_valid   <= 1'b0;
      if_insn    <= NOP_INSN;
      if_pc      <= 32'h0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        // pc already holds the target, so any in-flight response is dropped, never used.
        pc         <= tgt;
        skid_valid <= 1'b0;
        trap       <= tgt_mis;
        if_valid   <= tgt_mis;
        if_insn    <= NOP_INSN;
        if (tgt_mis) if_pc <= tgt;
      end else begin
        if (deliver) pc <= pc + 32'd4;
        if (trap) begin
          if_valid <= 1'b1;
        end else if (skid_valid && !stall) begin
          if_insn    <= skid_insn;
          if_pc      <= skid_pc;
          if_valid   <= 1'b1;
          skid_valid <= 1'b0;
        end else if (deliver && (!if_valid || !stall)) begin
          if_insn  <= imem_rdata;
          if_pc    <= pc;
          if_valid <= 1'b1;
        end else if (deliver) begin
          skid_insn  <= imem_rdata;
          skid_pc    <= pc;
          skid_valid <= 1'b1;
        end else if (!stall) begin
          if_valid <= 1'b0;
          if_insn  <= NOP_INSN;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios on a scripted memory, then random
// stalls/branches/flushes checked against a program-order model of the consumed stream.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_exp_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  logic [31:0] grant_log[$];
  logic [31:0] exp_q[$];

  if_fetch #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_taken(br_taken), .br_addr(br_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_insn(if_insn), .if_pc(if_pc), .if_valid(if_valid), .if_exp_misalign(if_exp_misalign)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    if ($urandom_range(3) == 0) t = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
    else                        t = $urandom & 32'h0000_FFFF;
`ifdef IF_MISALIGN_EXP_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: memory responder for the coming edge, decided from settled outputs
  task automatic mem_drive();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word(mem_addr);
        mem_busy    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (imem_req && !mem_busy && !imem_rvalid && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt = 1'b1;
      mem_addr = imem_addr;
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
      grant_log.push_back(imem_addr);
    end
  endtask

  task automatic step();
    mem_drive();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mem_clear();
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    grant_log.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    br_taken = 1'b0;
    mem_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      step();
    end
  endtask

  // random-phase model variables
  logic [31:0] exp_pc;
  logic        hold_prev;
  logic [31:0] held_pc;
  logic [31:0] held_insn;
  int          consumed;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_pc = 32'h0; br_taken = 1'b0; br_addr = 32'h0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    mem_clear();

    // reset values while rst is held
    @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_insn", if_insn, NOP_INSN);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_exp", 32'(if_exp_misalign), 32'd0);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, RESET_PC);

    // zero-wait memory: fetch 0x0, 0x4, 0x8
    do_reset();
    check("zw_c0_req", 32'(imem_req), 32'd1);
    check("zw_c0_addr", imem_addr, 32'h0);
    step();
    check("zw_c1_req", 32'(imem_req), 32'd0);
    step();
    check("zw_c2_valid", 32'(if_valid), 32'd1);
    check("zw_c2_pc", if_pc, 32'h0);
    check("zw_c2_insn", if_insn, word(32'h0));
    check("zw_c2_addr", imem_addr, 32'h4);
    step();
    check("zw_c3_valid", 32'(if_valid), 32'd0);
    check("zw_c3_insn", if_insn, NOP_INSN);
    step();
    check("zw_c4_valid", 32'(if_valid), 32'd1);
    check("zw_c4_pc", if_pc, 32'h4);
    step();
    exp_q = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++)
      check("zw_addr_seq", (grant_log.size() > i) ? grant_log[i] : 32'hFFFF_FFFF, exp_q[i]);

    // stall while the 0x4 response arrives -> skid
    do_reset();
    step();
    step();
    check("sk_pc0", if_pc, 32'h0);
    stall = 1'b1;
    step();
    step();
    check("sk_hold_valid", 32'(if_valid), 32'd1);
    check("sk_hold_pc", if_pc, 32'h0);
    check("sk_no_req", 32'(imem_req), 32'd0);
    step();
    check("sk_no_req2", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("sk_rel_valid", 32'(if_valid), 32'd1);
    check("sk_rel_pc", if_pc, 32'h4);
    check("sk_rel_insn", if_insn, word(32'h4));
    check("sk_rel_req", 32'(imem_req), 32'd1);
    check("sk_rel_addr", imem_addr, 32'h8);

    // taken branch while 0xC is outstanding
    step();
    step();
    check("br_pc8", if_pc, 32'h8);
    check("br_addrC", imem_addr, 32'hC);
    lat_min = 2; lat_max = 2; stall = 1'b1;
    step();
    check("br_hold_pc8", if_pc, 32'h8);
    stall = 1'b0; br_taken = 1'b1; br_addr = 32'h100;
    step();
    br_taken = 1'b0;
    check("br_valid_off", 32'(if_valid), 32'd0);
    check("br_drop_noreq", 32'(imem_req), 32'd0);
    lat_min = 1; lat_max = 1;
    step();
    check("br_req", 32'(imem_req), 32'd1);
    check("br_addr", imem_addr, 32'h100);
    wait_valid();
    check("br_first_pc", if_pc, 32'h100);
    check("br_first_insn", if_insn, word(32'h100));

    // flush beats br_taken in the same cycle
    flush = 1'b1; flush_pc = 32'h200; br_taken = 1'b1; br_addr = 32'h100;
    step();
    flush = 1'b0; br_taken = 1'b0;
    grant_log.delete();
    check("fl_valid_off", 32'(if_valid), 32'd0);
    wait_valid();
    check("fl_first_pc", if_pc, 32'h200);
    check("fl_first_fetch", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF, 32'h200);

    // asynchronous reset during S_WAIT
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_valid();
    stall = 1'b1;
    step();
    check("ar_pre_valid", 32'(if_valid), 32'd1);
    check("ar_pre_busy", 32'(mem_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(if_valid), 32'd0);
    check("ar_insn", if_insn, NOP_INSN);
    check("ar_req", 32'(imem_req), 32'd1);
    check("ar_addr", imem_addr, RESET_PC);
    stall = 1'b0;
    mem_clear();
    @(negedge clk);
    rst = 1'b0;
    check("ar_rel_req", 32'(imem_req), 32'd1);
    check("ar_rel_addr", imem_addr, RESET_PC);

    // misaligned branch target
    lat_min = 1; lat_max = 1;
    wait_valid();
    br_taken = 1'b1; br_addr = 32'h102;
    step();
    br_taken = 1'b0;
    grant_log.delete();
`ifdef IF_MISALIGN_EXP_EN
    check("ma_exp", 32'(if_exp_misalign), 32'd1);
    check("ma_pc", if_pc, 32'h102);
    check("ma_valid", 32'(if_valid), 32'd1);
    check("ma_insn", if_insn, NOP_INSN);
    for (int i = 0; i < 5; i++) begin
      stall = ($urandom_range(1) == 1);
      br_taken = 1'b1; br_addr = 32'h400;
      step();
      check("ma_no_req", 32'(imem_req), 32'd0);
      check("ma_sticky", 32'(if_exp_misalign), 32'd1);
      check("ma_sticky_pc", if_pc, 32'h102);
    end
    stall = 1'b0; br_taken = 1'b0;
    flush = 1'b1; flush_pc = 32'h300;
    step();
    flush = 1'b0;
    check("ma_clear", 32'(if_exp_misalign), 32'd0);
    grant_log.delete();
    wait_valid();
    check("ma_flush_pc", if_pc, 32'h300);
    check("ma_flush_fetch", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF, 32'h300);
`else
    check("ma_exp_tied", 32'(if_exp_misalign), 32'd0);
    wait_valid();
    check("ma_aligned_pc", if_pc, 32'h100);
    check("ma_aligned_fetch", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF_FFFF, 32'h100);
`endif

    // random phase: consumed stream must follow program order with redirects
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    do_reset();
    exp_pc = RESET_PC; hold_prev = 1'b0; held_pc = 32'h0; held_insn = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_one_outstanding", 32'(imem_req && mem_busy), 32'd0);
      if (!if_valid) check("rnd_nop_invalid", if_insn, NOP_INSN);
      if (hold_prev) begin
        check("rnd_hold_valid", 32'(if_valid), 32'd1);
        check("rnd_hold_pc", if_pc, held_pc);
        check("rnd_hold_insn", if_insn, held_insn);
      end
      stall    = ($urandom_range(99) < 30);
      flush    = ($urandom_range(99) < 3);
      br_taken = ($urandom_range(99) < 8);
      flush_pc = rand_tgt();
      br_addr  = rand_tgt();
      if (flush) begin
        exp_pc = flush_pc & ~32'h3;
      end else if (if_valid && !stall) begin
        check("rnd_pc", if_pc, exp_pc);
        check("rnd_insn", if_insn, word(exp_pc));
        consumed++;
        exp_pc = br_taken ? (br_addr & ~32'h3) : exp_pc + 32'd4;
      end
      hold_prev = if_valid && stall && !flush;
      held_pc   = if_pc;
      held_insn = if_insn;
      step();
    end
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    check("rnd_progress", 32'(consumed > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
